// File: rtl/axi_bresp_buffer.sv
// rtl/axi_bresp_buffer.sv - fall-through FIFO of AXI write responses with a saturating error counter
module axi_bresp_buffer #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     S_VALID,
  output logic                     S_READY,
  input  logic [1:0]               S_BRESP,
  input  logic [ID_W-1:0]          S_BID,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [1:0]               BRESP,
  output logic [ID_W-1:0]          BID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [7:0]               ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ID_W + 2;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    err_q, err_d;
  logic [EW-1:0] head;
  logic          push, pop;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign S_READY = (count_q < CNT_FULL);
  assign BVALID  = (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign BRESP   = BVALID ? head[EW-1 -: 2] : 2'b00;
  assign BID     = BVALID ? head[ID_W-1:0] : '0;
  assign COUNT   = count_q;
  assign ERR_CNT = err_q;

  assign push = S_VALID && S_READY;
  assign pop  = BVALID && BREADY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (pop && head[EW-1] && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push) mem_q[wr_ptr_q] <= {S_BRESP, S_BID};
    end
  end

endmodule

// File: tb/tb_axi_bresp_buffer.sv
// tb/tb_axi_bresp_buffer.sv - scoreboard bench for axi_bresp_buffer
module tb_axi_bresp_buffer;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       S_VALID;
  logic       S_READY;
  logic [1:0] S_BRESP;
  logic [3:0] S_BID;
  logic       BVALID;
  logic       BREADY;
  logic [1:0] BRESP;
  logic [3:0] BID;
  logic [2:0] COUNT;
  logic [7:0] ERR_CNT;

  int n_checks = 0;
  int n_fails  = 0;
  int merr     = 0;
  logic [5:0] sb_q [$];

  axi_bresp_buffer #(.ID_W(4), .DEPTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_BRESP(S_BRESP), .S_BID(S_BID),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .COUNT(COUNT), .ERR_CNT(ERR_CNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic sv, input logic [1:0] resp, input logic [3:0] id, input logic br);
    logic [5:0] head;
    bit mpush, mpop;
    S_VALID = sv; S_BRESP = resp; S_BID = id; BREADY = br;
    #1;
    check("s_ready", S_READY, sb_q.size() < 4);
    check("bvalid", BVALID, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      check("bresp", BRESP, head[5:4]);
      check("bid", BID, head[3:0]);
    end else begin
      check("bresp_idle", BRESP, 0);
      check("bid_idle", BID, 0);
    end
    mpop  = (sb_q.size() != 0) && br;
    mpush = sv && (sb_q.size() < 4);
    if (mpop) begin
      head = sb_q.pop_front();
      if (head[5] && merr < 255) merr++;
    end
    if (mpush) sb_q.push_back({resp, id});
    @(posedge ACLK);
    @(negedge ACLK);
    check("count", COUNT, sb_q.size());
    check("err_cnt", ERR_CNT, merr);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'b00, 4'h0, 1'b1);
  endtask

  initial begin
    logic [1:0] fill_resp [4];
    fill_resp = '{2'b01, 2'b10, 2'b11, 2'b00};
    ARESET = 1'b1; S_VALID = 1'b0; S_BRESP = 2'b00; S_BID = 4'h0; BREADY = 1'b0;
    #3;
    check("rst_bvalid", BVALID, 0);
    check("rst_s_ready", S_READY, 1);
    check("rst_count", COUNT, 0);
    check("rst_err", ERR_CNT, 0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // single response held under backpressure
    cycle(1'b1, 2'b00, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 4'h0, 1'b0);
    cycle(1'b0, 2'b00, 4'h0, 1'b1);
    cycle(1'b0, 2'b00, 4'h0, 1'b0);

    // fill, reject a fifth, drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_resp[i], 4'(i), 1'b0);
    cycle(1'b1, 2'b00, 4'd9, 1'b0);
    drain();
    check("err_after_fill", ERR_CNT, 2);

    // full with simultaneous pop: pop only, then push+pop steady state
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'b00, 4'(i + 4), 1'b0);
    cycle(1'b1, 2'b01, 4'd12, 1'b1);
    check("full_pop_count", COUNT, 3);
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'(i), 4'(13 + i), 1'b1);
    check("steady_count", COUNT, 3);
    drain();

    // streaming with wrap
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), 4'(i), 1'b1);
      check("stream_cnt_le1", COUNT <= 3'd1, 1);
    end
    drain();

    // error counter saturation
    for (int i = 0; i < 260; i++) cycle(1'b1, 2'b11, 4'(i), 1'b1);
    drain();
    check("err_saturated", ERR_CNT, 255);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b10, 4'(i + 1), 1'b0);
    S_VALID = 1'b0; BREADY = 1'b0;
    #2 ARESET = 1'b1;
    #1;
    check("amid_bvalid", BVALID, 0);
    check("amid_bresp", BRESP, 0);
    check("amid_bid", BID, 0);
    check("amid_count", COUNT, 0);
    check("amid_err", ERR_CNT, 0);
    check("amid_s_ready", S_READY, 1);
    sb_q.delete();
    merr = 0;
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    cycle(1'b1, 2'b10, 4'hA, 1'b0);
    cycle(1'b0, 2'b00, 4'h0, 1'b1);
    cycle(1'b0, 2'b00, 4'h0, 1'b0);
    check("post_rst_err", ERR_CNT, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
